// File: rtl/clock_div_prog.sv
// Runtime-programmable integer clock divider (N = 2..2^CNT_W-1), glitch-free ratio changes and run/stop.
// Optional macro CLK_DIV_DUTY50_EN adds a negedge flop so odd ratios get 50% duty.
module clock_div_prog #(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  input  logic             div_load,
  output logic             clk_div,
  output logic             div_tick,
  output logic [CNT_W-1:0] div_active,
  output logic             load_err
);

  if (DIV_RST < 2 || DIV_RST > (2**CNT_W) - 1) begin : g_bad_div_rst
    $error("clock_div_prog: DIV_RST must be in 2..2^CNT_W-1");
  end

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt, cnt_inc, pend_val;
  logic             pend, clk_pos;
  logic             ld_ok, ld_bad, wrap, bound;

  assign cnt_inc = cnt + CNT_W'(1);
  assign ld_ok   = div_load && (div >  CNT_W'(1));
  assign ld_bad  = div_load && (div <= CNT_W'(1));
  assign wrap    = (st != IDLE) && (cnt == div_active - CNT_W'(1));
  // Ratio changes are only allowed where no period is in flight.
  assign bound   = (st == IDLE) || wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      cnt        <= '0;
      pend       <= 1'b0;
      pend_val   <= '0;
      clk_pos    <= 1'b0;
      div_tick   <= 1'b0;
      load_err   <= 1'b0;
      div_active <= CNT_W'(DIV_RST);
    end else begin
      load_err <= ld_bad;
      div_tick <= 1'b0;

      if (bound) begin
        if (ld_ok)     div_active <= div;
        else if (pend) div_active <= pend_val;
        pend <= 1'b0;
      end else if (ld_ok) begin
        pend_val <= div;
        pend     <= 1'b1;
      end

      case (st)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            st       <= RUN;
            clk_pos  <= 1'b1;
            div_tick <= 1'b1;
          end else begin
            clk_pos  <= 1'b0;
          end
        end
        default: begin
          // Stopping only takes effect at the end of a period.
          if (wrap && !en) begin
            st      <= IDLE;
            cnt     <= '0;
            clk_pos <= 1'b0;
          end else begin
            st <= en ? RUN : STOPPING;
            if (wrap) begin
              cnt      <= '0;
              clk_pos  <= 1'b1;
              div_tick <= 1'b1;
            end else begin
              cnt     <= cnt_inc;
              clk_pos <= cnt_inc < (div_active >> 1);
            end
          end
        end
      endcase
    end
  end

`ifdef CLK_DIV_DUTY50_EN
  logic clk_neg;

  // Half-cycle-delayed copy of the high phase stretches odd ratios to N/2 high.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) clk_neg <= 1'b0;
    else        clk_neg <= clk_pos & div_active[0];
  end

  assign clk_div = clk_pos | clk_neg;
`else
  assign clk_div = clk_pos;
`endif

endmodule

// File: tb/tb_clock_div_prog.sv
// Bench for clock_div_prog: queue-based per-period reference model, load table, corner sequences, random run.
module tb_clock_div_prog;
  localparam int CNT_W   = 8;
  localparam int DIV_RST = 2;
`ifdef CLK_DIV_DUTY50_EN
  localparam int T2_HI = 3;
`else
  localparam int T2_HI = 2;
`endif

  logic             clk = 1'b0, rst_n = 1'b0, en = 1'b0, div_load = 1'b0;
  logic [CNT_W-1:0] div = '0;
  logic             clk_div, div_tick, load_err;
  logic [CNT_W-1:0] div_active;

  clock_div_prog #(.CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div(div), .div_load(div_load),
    .clk_div(clk_div), .div_tick(div_tick), .div_active(div_active), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: each period is materialised as a queue of per-cycle output values.
  bit m_act, m_pend, m_err, prev_pos, prev_odd;
  bit q_clk[$];
  bit q_tick[$];
  int m_n, m_pv;

  function automatic bit cur_pos();
    return m_act ? q_clk[0] : 1'b0;
  endfunction

  function automatic void m_reset();
    m_act = 0; m_pend = 0; m_err = 0; prev_pos = 0; prev_odd = 0;
    q_clk.delete(); q_tick.delete();
    m_n = DIV_RST; m_pv = 0;
  endfunction

  function automatic void m_edge(bit e, bit ld, int d);
    bit bnd;
    prev_pos = cur_pos();
    prev_odd = m_n[0];
    if (m_act) begin
      void'(q_clk.pop_front());
      void'(q_tick.pop_front());
    end
    bnd   = !m_act || (q_clk.size() == 0);
    m_err = ld && (d < 2);
    if (bnd) begin
      if (ld && d >= 2) m_n = d;
      else if (m_pend)  m_n = m_pv;
      m_pend = 0;
      m_act  = e;
      if (e)
        for (int i = 0; i < m_n; i++) begin
          q_clk.push_back(i < m_n / 2);
          q_tick.push_back(i == 0);
        end
    end else if (ld && d >= 2) begin
      m_pv = d; m_pend = 1;
    end
  endfunction

  function automatic bit exp_clk();
`ifdef CLK_DIV_DUTY50_EN
    return cur_pos() | (prev_pos & prev_odd);
`else
    return cur_pos();
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("clk_div", {31'd0, clk_div}, {31'd0, exp_clk()});
    chk("div_tick", {31'd0, div_tick}, {31'd0, m_act ? q_tick[0] : 1'b0});
    chk("div_active", {24'd0, div_active}, m_n);
    chk("load_err", {31'd0, load_err}, {31'd0, m_err});
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) m_reset();
    else        m_edge(en, div_load, int'(div));
    #2;
    compare_all();
  endtask

  task automatic wait_tick(int max);
    for (int i = 0; i < max; i++) begin
      step();
      if (div_tick) return;
    end
    chk("wait_tick_timeout", 0, 1);
  endtask

  task automatic load(int d);
    div = CNT_W'(d); div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  typedef struct { int d; bit err; int act; } vec_t;
  vec_t tbl[7];

  initial begin
    int hi, tk;
    tbl[0] = '{5,   1'b0, 5};
    tbl[1] = '{1,   1'b1, 5};
    tbl[2] = '{0,   1'b1, 5};
    tbl[3] = '{255, 1'b0, 255};
    tbl[4] = '{2,   1'b0, 2};
    tbl[5] = '{4,   1'b0, 4};
    tbl[6] = '{1,   1'b1, 4};

    m_reset();
    repeat (2) step();
    chk("rst_active", {24'd0, div_active}, DIV_RST);
    chk("rst_clk", {31'd0, clk_div}, 0);
    rst_n = 1'b1;

    // N=2 straight out of reset
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t1_clk", {31'd0, clk_div}, (i % 2 == 0) ? 1 : 0);
      chk("t1_tick", {31'd0, div_tick}, (i % 2 == 0) ? 1 : 0);
    end

    // Load table applied while idle: legal ratios take effect at once
    en = 1'b0;
    repeat (3) step();
    foreach (tbl[i]) begin
      load(tbl[i].d);
      chk("tbl_err", {31'd0, load_err}, {31'd0, tbl[i].err});
      chk("tbl_act", {24'd0, div_active}, tbl[i].act);
      step();
      chk("tbl_err_clr", {31'd0, load_err}, 0);
    end

    // N=4 running, load 8 at cnt=1: old period completes first
    en = 1'b1;
    step();
    chk("t3_start_tick", {31'd0, div_tick}, 1);
    step();
    load(8);
    chk("t3_hold_a", {24'd0, div_active}, 4);
    step();
    chk("t3_hold_b", {24'd0, div_active}, 4);
    chk("t3_hold_clk", {31'd0, clk_div}, 0);
    step();
    chk("t3_new", {24'd0, div_active}, 8);
    chk("t3_wrap_tick", {31'd0, div_tick}, 1);
    hi = clk_div;
    for (int i = 0; i < 7; i++) begin step(); hi += clk_div; end
    chk("t3_high_cycles", hi, 4);

    // Switch to N=5: duty and tick spacing
    load(5);
    wait_tick(20);
    chk("t2_act", {24'd0, div_active}, 5);
    hi = clk_div;
    for (int i = 0; i < 4; i++) begin step(); hi += clk_div; end
    chk("t2_high_samples", hi, T2_HI);
    tk = 0;
    for (int i = 0; i < 10; i++) begin step(); tk += div_tick; end
    chk("t2_ticks", tk, 2);

    // Illegal ratios rejected while running
    load(1);
    chk("t4_err1", {31'd0, load_err}, 1);
    chk("t4_act1", {24'd0, div_active}, 5);
    load(0);
    chk("t4_err0", {31'd0, load_err}, 1);
    step();
    chk("t4_err_clr", {31'd0, load_err}, 0);
    chk("t4_act0", {24'd0, div_active}, 5);

    // N=6: drop en at cnt=1, period completes, then idle
    load(6);
    wait_tick(20);
    step();
    en = 1'b0;
    repeat (4) step();
    chk("t5_last_cycle_tick", {31'd0, div_tick}, 0);
    step();
    chk("t5_idle_clk", {31'd0, clk_div}, 0);
    step();
    chk("t5_idle_tick", {31'd0, div_tick}, 0);
    en = 1'b1;
    step();
    chk("t5_restart_clk", {31'd0, clk_div}, 1);
    chk("t5_restart_tick", {31'd0, div_tick}, 1);
    // re-assert during the stopping period: no gap
    step();
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (2) step();
    step();
    chk("t5_unbroken_tick", {31'd0, div_tick}, 1);

    // Async reset mid-high-phase with a pending load
    wait_tick(20);
    load(10);
    step();
    chk("t6_high_before", {31'd0, clk_div}, 1);
    #1 rst_n = 1'b0;
    #1 m_reset();
    compare_all();
    chk("t6_clk_now", {31'd0, clk_div}, 0);
    chk("t6_act_now", {24'd0, div_active}, DIV_RST);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_act_after", {24'd0, div_active}, DIV_RST);
    end

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      en       = ($urandom_range(0, 15) != 0) ? (i % 600 < 450) : $urandom_range(0, 1) != 0;
      div_load = ($urandom_range(0, 9) == 0);
      div      = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom_range(0, 255))
                                               : CNT_W'($urandom_range(0, 12));
      if ($urandom_range(0, 799) == 0) begin
        #1 rst_n = 1'b0;
        #1 m_reset();
        compare_all();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
